// File: rtl/modmul_pkg.sv
// modmul_pkg: shared constants, pipe tag type and the mod-Q folding reduction.
// Q = 2^32 - 2^13 - 2^11 + 1, so 2^32 folds to 2^13 + 2^11 - 1.
package modmul_pkg;
   localparam int          W     = 32;
   localparam logic [W-1:0] Q_MOD = 32'd4294957057;
   localparam int          R_HI  = 13;
   localparam int          R_LO  = 11;
   localparam int          ID_W  = 3;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   // Three folds bring a 64-bit product below 2Q; one conditional subtract finishes.
   function automatic logic [W-1:0] mod_fold(input logic [2*W-1:0] x);
      logic [46:0] s1;
      logic [33:0] s2;
      logic [32:0] s3;
      s1 = 47'(x[W-1:0]) + (47'(x[2*W-1:W]) << R_HI) + (47'(x[2*W-1:W]) << R_LO) - 47'(x[2*W-1:W]);
      s2 = 34'(s1[31:0]) + (34'(s1[46:32]) << R_HI) + (34'(s1[46:32]) << R_LO) - 34'(s1[46:32]);
      s3 = 33'(s2[31:0]) + (33'(s2[33:32]) << R_HI) + (33'(s2[33:32]) << R_LO) - 33'(s2[33:32]);
      return (s3 >= 33'(Q_MOD)) ? W'(s3 - 33'(Q_MOD)) : W'(s3);
   endfunction
endpackage

// File: rtl/modmul_pipe.sv
// modmul_pipe: Karatsuba 32x32 multiplier with mod-Q reduction over LAT register stages.
// Operands register at stage 1; the {valid,id} tag shifts alongside and never stalls.
module modmul_pipe
   import modmul_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [ID_W-1:0] in_id,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic            out_valid,
   output logic [ID_W-1:0] out_id,
   output logic [W-1:0]    p
);
   tag_t        tag_q [LAT];
   logic [W-1:0] a_q, b_q, mul_p, z2, z0;
   logic [16:0] sa, sb;
   logic [33:0] z1;

   always_comb begin
      sa    = 17'(a_q[31:16]) + 17'(a_q[15:0]);
      sb    = 17'(b_q[31:16]) + 17'(b_q[15:0]);
      z2    = 32'(a_q[31:16]) * 32'(b_q[31:16]);
      z0    = 32'(a_q[15:0]) * 32'(b_q[15:0]);
      z1    = 34'(sa) * 34'(sb) - 34'(z2) - 34'(z0);
      mul_p = mod_fold({z2, z0} + (64'(z1) << 16));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         tag_q[0] <= {in_valid, in_id};
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
         if (in_valid) begin
            a_q <= a;
            b_q <= b;
         end
      end
   end

   if (LAT == 1) begin : g_lat1
      assign p = mul_p;
   end else begin : g_latn
      logic [W-1:0] res_q [LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < LAT-1; i++) res_q[i] <= '0;
         end else begin
            res_q[0] <= mul_p;
            for (int i = 1; i < LAT-1; i++) res_q[i] <= res_q[i-1];
         end
      end
      assign p = res_q[LAT-2];
   end

   assign out_valid = tag_q[LAT-1].valid;
   assign out_id    = tag_q[LAT-1].id;
endmodule

// File: rtl/modmul_sched.sv
// modmul_sched: round-robin scheduler for a shared mod-Q multiplier with a credit-protected FWFT result FIFO.
// Defining MODMUL_SCHED_STATS_EN adds saturating stat_issue/stat_stall counters.
module modmul_sched
   import modmul_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int LAT   = 2,
   parameter  int DEPTH = 4,
   localparam int IW    = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*W-1:0] req_a,
   input  logic [N*W-1:0] req_b,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IW-1:0]  rsp_id,
   output logic [W-1:0]   rsp_p
`ifdef MODMUL_SCHED_STATS_EN
  ,output logic [31:0]    stat_issue,
   output logic [31:0]    stat_stall
`endif
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   logic [IW-1:0]   rr_q, gnt, idx;
   logic            any_v, credit_ok, accept, pop, push, pipe_v;
   logic [OW-1:0]   occ_q, occ_d, cnt_q, cnt_d;
   logic [PW-1:0]   rd_q, wr_q;
   logic [W-1:0]    fifo_p_q [DEPTH];
   logic [ID_W-1:0] fifo_id_q [DEPTH];
   logic [ID_W-1:0] pipe_id, head_id;
   logic [W-1:0]    pipe_p;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   // Descending scan so the requester nearest after rr_q is the last (winning) write.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      any_v = 1'b0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(rr_q) + k) % N);
         if (req_valid[idx]) begin
            gnt   = idx;
            any_v = 1'b1;
         end
      end
   end

   assign rsp_valid = (cnt_q != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign credit_ok = (occ_q < OW'(DEPTH)) || ((occ_q == OW'(DEPTH)) && pop);
   assign req_ready = (rst_n && any_v && credit_ok) ? (N'(1) << gnt) : '0;
   assign accept    = |(req_valid & req_ready);
   assign push      = pipe_v;
   assign occ_d     = occ_q + OW'(accept) - OW'(pop);
   assign cnt_d     = cnt_q + OW'(push) - OW'(pop);
   assign head_id   = fifo_id_q[rd_q];
   assign rsp_id    = rsp_valid ? head_id[IW-1:0] : '0;
   assign rsp_p     = rsp_valid ? fifo_p_q[rd_q] : '0;

   modmul_pipe #(.LAT(LAT)) u_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (accept),
      .in_id    (ID_W'(gnt)),
      .a        (req_a[32'(gnt)*W +: W]),
      .b        (req_b[32'(gnt)*W +: W]),
      .out_valid(pipe_v),
      .out_id   (pipe_id),
      .p        (pipe_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q  <= IW'(N - 1);
         occ_q <= '0;
         cnt_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_p_q[i]  <= '0;
            fifo_id_q[i] <= '0;
         end
      end else begin
         if (accept) rr_q <= gnt;
         occ_q <= occ_d;
         cnt_q <= cnt_d;
         if (push) begin
            fifo_p_q[wr_q]  <= pipe_p;
            fifo_id_q[wr_q] <= pipe_id;
            wr_q            <= nxt(wr_q);
         end
         if (pop) rd_q <= nxt(rd_q);
      end
   end

`ifdef MODMUL_SCHED_STATS_EN
   logic [31:0] issue_q, stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_q <= '0;
         stall_q <= '0;
      end else begin
         if (accept && issue_q != '1) issue_q <= issue_q + 32'd1;
         if (any_v && !credit_ok && stall_q != '1) stall_q <= stall_q + 32'd1;
      end
   end
   assign stat_issue = issue_q;
   assign stat_stall = stall_q;
`endif

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt_q == OW'(DEPTH) && !pop));
   a_id_range: assert property (@(posedge clk) disable iff (!rst_n) !rsp_valid || int'(head_id) < N);
endmodule
